// File: rtl/rf_wr_arbiter.sv
// Two-requester round-robin write arbiter feeding a register file through one registered write port.
// Define RF_INIT_SEQ_EN to add a power-up sequence that writes every register before arbitration starts.
module rf_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  a_ready,
  output logic                  b_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  init_busy
);

  logic                  r_last_b;
  logic                  r_vld_p1;
  logic [ADDR_WIDTH-1:0] r_addr_p1;
  logic [DATA_WIDTH-1:0] r_data_p1;
  logic                  w_in_arb;
  logic                  w_a_gnt;
  logic                  w_b_gnt;
  logic                  w_vld_p0;
  logic [ADDR_WIDTH-1:0] w_addr_p0;
  logic [DATA_WIDTH-1:0] w_data_p0;

`ifdef RF_INIT_SEQ_EN
  typedef enum logic {S_INIT, S_ARB} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_init_cnt;

  function automatic logic [DATA_WIDTH-1:0] init_data(input logic [ADDR_WIDTH-1:0] addr);
    return (32'(addr) == 32'd6) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
  endfunction

  assign w_in_arb  = (r_state == S_ARB);
  assign init_busy = (r_state == S_INIT);
`else
  assign w_in_arb  = 1'b1;
  assign init_busy = 1'b0;
`endif

  // Tie goes to whichever requester did not win the previous transfer
  assign w_a_gnt = w_in_arb & a_valid & (~b_valid | r_last_b);
  assign w_b_gnt = w_in_arb & b_valid & (~a_valid | ~r_last_b);
  assign a_ready = w_a_gnt;
  assign b_ready = w_b_gnt;

  always_comb begin
    w_vld_p0  = w_a_gnt | w_b_gnt;
    w_addr_p0 = r_addr_p1;
    w_data_p0 = r_data_p1;
    if (w_a_gnt) begin
      w_addr_p0 = a_addr;
      w_data_p0 = a_data;
    end else if (w_b_gnt) begin
      w_addr_p0 = b_addr;
      w_data_p0 = b_data;
    end
`ifdef RF_INIT_SEQ_EN
    if (r_state == S_INIT) begin
      w_vld_p0  = 1'b1;
      w_addr_p0 = r_init_cnt;
      w_data_p0 = init_data(r_init_cnt);
    end
`endif
  end

  // p0 -> p1: registered write port; address/data hold whenever no write is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_addr_p1 <= '0;
      r_data_p1 <= '0;
      r_last_b  <= 1'b1;
`ifdef RF_INIT_SEQ_EN
      r_state    <= S_INIT;
      r_init_cnt <= '0;
`endif
    end else begin
      r_vld_p1  <= w_vld_p0;
      r_addr_p1 <= w_addr_p0;
      r_data_p1 <= w_data_p0;
      if (w_a_gnt | w_b_gnt)
        r_last_b <= w_b_gnt;
`ifdef RF_INIT_SEQ_EN
      if (r_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (r_init_cnt == {ADDR_WIDTH{1'b1}})
          r_state <= S_ARB;
      end
`endif
    end
  end

  assign wr_en  = r_vld_p1;
  assign w_addr = r_addr_p1;
  assign w_data = r_data_p1;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: table of single-cycle vectors plus hand sequences for reset/tie/init cases.
module tb_rf_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [2:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, wr_en, init_busy;
  logic [2:0] w_addr;
  logic [7:0] w_data;

  int n_vec  = 0;
  int n_fail = 0;

  rf_wr_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
    .a_ready(a_ready), .b_ready(b_ready),
    .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       av;
    logic [2:0] aa;
    logic [7:0] ad;
    logic       bv;
    logic [2:0] ba;
    logic [7:0] bd;
    logic       ar;
    logic       br;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered and left at a negedge; applies a reset edge and checks the reset state.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef RF_INIT_SEQ_EN
  task automatic init_run();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("init_busy_hi", 32'(init_busy), 32'd1);
      chk("init_a_ready", 32'(a_ready), 32'd0);
      chk("init_b_ready", 32'(b_ready), 32'd0);
      @(posedge clk); #1;
      chk("init_wr_en", 32'(wr_en), 32'd1);
      chk("init_w_addr", 32'(w_addr), 32'(k));
      chk("init_w_data", 32'(w_data), (k == 6) ? 32'hFF : 32'h00);
      @(negedge clk);
    end
    #1;
    chk("init_busy_lo", 32'(init_busy), 32'd0);
  endtask
`endif

  initial begin
    // Starts right after reset, so last grant is B and A wins the first tie
    vecs[0] = '{1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h5A};
    vecs[1] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'h5A};
    vecs[2] = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 1'b1, 1'b1, 3'd2, 8'h22};
    vecs[3] = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b1, 1'b0, 1'b1, 3'd1, 8'h11};
    vecs[4] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h33, 1'b0, 1'b1, 1'b1, 3'd5, 8'h33};
    vecs[5] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h44, 1'b0, 1'b1, 1'b1, 3'd6, 8'h44};
    vecs[6] = '{1'b1, 3'd7, 8'h77, 1'b1, 3'd0, 8'h80, 1'b1, 1'b0, 1'b1, 3'd7, 8'h77};
    vecs[7] = '{1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 8'hFF};
    vecs[8] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'hFF};
    vecs[9] = '{1'b1, 3'd2, 8'h01, 1'b1, 3'd4, 8'hFE, 1'b0, 1'b1, 1'b1, 3'd4, 8'hFE};

    @(negedge clk);
    do_reset();
`ifdef RF_INIT_SEQ_EN
    chk("post_rst_init_busy", 32'(init_busy), 32'd1);
    init_run();
`else
    chk("post_rst_init_busy", 32'(init_busy), 32'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      #1;
      chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ar));
      chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].br));
      @(posedge clk); #1;
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].we));
      chk($sformatf("v%0d_w_addr", i), 32'(w_addr), 32'(vecs[i].wa));
      chk($sformatf("v%0d_w_data", i), 32'(w_data), 32'(vecs[i].wd));
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Both valid straight from reset (and through init if present): A,B,A,B
    a_valid = 1'b1; a_addr = 3'd1; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 8'h22;
    do_reset();
`ifdef RF_INIT_SEQ_EN
    init_run();
`endif
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_a_ready", i), 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_b_ready", i), 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      chk($sformatf("rr%0d_wr_en", i), 32'(wr_en), 32'd1);
      chk($sformatf("rr%0d_w_data", i), 32'(w_data), (i % 2 == 0) ? 32'h11 : 32'h22);
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;

`ifdef RF_INIT_SEQ_EN
    // Reset pulsed at init count 4 restarts the sequence at address 0
    do_reset();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midinit_rst_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    init_run();
`endif

    // Leave last grant at A, then a B transfer coincident with reset must be dropped
    a_valid = 1'b1; a_addr = 3'd4; a_data = 8'h3C;
    #1;
    chk("pre_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    chk("pre_w_data", 32'(w_data), 32'h3C);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b1; b_addr = 3'd5; b_data = 8'h55;
    rst = 1'b1;
    #1;
    chk("rstb_b_ready", 32'(b_ready), 32'd1);
    @(posedge clk); #1;
    chk("rstb_wr_en", 32'(wr_en), 32'd0);
    chk("rstb_w_data", 32'(w_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    b_valid = 1'b0;
`ifdef RF_INIT_SEQ_EN
    init_run();
`endif
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("tie_a_ready", 32'(a_ready), 32'd1);
    chk("tie_b_ready", 32'(b_ready), 32'd0);
    @(posedge clk); #1;
    chk("tie_wr_en", 32'(wr_en), 32'd1);
    chk("tie_w_addr", 32'(w_addr), 32'd4);
    chk("tie_w_data", 32'(w_data), 32'h3C);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
